// File: rtl/traffic_display_pkg.sv
// Shared constants for the traffic display mux: segment patterns, mode codes
// and the BCD to 7-segment decoder (abcdefg, bit6 = a, active-high).
package traffic_display_pkg;

   localparam logic [6:0] SEG_0     = 7'h7E;
   localparam logic [6:0] SEG_1     = 7'h30;
   localparam logic [6:0] SEG_2     = 7'h6D;
   localparam logic [6:0] SEG_3     = 7'h79;
   localparam logic [6:0] SEG_4     = 7'h33;
   localparam logic [6:0] SEG_5     = 7'h5B;
   localparam logic [6:0] SEG_6     = 7'h5F;
   localparam logic [6:0] SEG_7     = 7'h70;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h7B;
   localparam logic [6:0] SEG_DASH  = 7'h01;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [1:0] MODE_NORMAL = 2'b00;
   localparam logic [1:0] MODE_NIGHT  = 2'b01;
   localparam logic [1:0] MODE_OFF    = 2'b10;
   localparam logic [1:0] MODE_TEST   = 2'b11;

   // Codes 10..15 are not valid BCD and are shown as a dash.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      logic [6:0] pattern;
      case (bcd)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_DASH;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/traffic_display_mux_scan_tick_gen.sv
// Scan prescaler: counts 0..SCAN_DIV-1 and flags the wrap cycle as a tick.
module scan_tick_gen #(
   parameter int SCAN_DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] count;

   assign tick = (count == LAST_COUNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/traffic_display_mux.sv
// Traffic lamp driver plus time-multiplexed 7-segment countdown display with
// frame-aligned loading, leading-zero blanking and night/off/lamp-test modes.
module traffic_display_mux
   import traffic_display_pkg::*;
#(
   parameter int NUM_DIGITS  = 2,
   parameter int SCAN_DIV    = 1000,
   parameter int BLINK_TICKS = 250,
   parameter int ACTIVE_LOW  = 0,
   parameter int LZ_BLANK    = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [2:0]              light_sel,
   input  logic [1:0]              mode,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic                    load,
   output logic                    led_red,
   output logic                    led_yellow,
   output logic                    led_green,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   dig_en
);

   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [BLINK_W-1:0]    LAST_BLINK = BLINK_W'(BLINK_TICKS - 1);
   localparam logic [6:0]            SEG_INV    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] DIG_INV    = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   logic                    tick;
   logic                    frameEnd;
   logic [IDX_W-1:0]        digitIdx;
   logic [IDX_W-1:0]        slotIdx;
   logic [IDX_W-1:0]        curIdx;
   logic                    slotValid;
   logic                    curValid;
   logic [6:0]              slotSeg;
   logic [6:0]              curSeg;
   logic [6:0]              digitSeg;
   logic [4*NUM_DIGITS-1:0] pendingVal;
   logic                    pendingValid;
   logic [4*NUM_DIGITS-1:0] displayVal;
   logic [BLINK_W-1:0]      blinkCnt;
   logic                    blinkPhase;
   logic                    selOneHot;
   logic [NUM_DIGITS-1:0]   zeroDigit;
   logic [NUM_DIGITS-1:0]   blankDigit;
   logic [NUM_DIGITS-1:0]   digOneHot;
   logic [6:0]              segTable [NUM_DIGITS];
   logic [6:0]              segNext;
   logic [NUM_DIGITS-1:0]   digNext;
   logic [2:0]              lampNext;

   scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_scan_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign frameEnd  = tick && (digitIdx == LAST_IDX);
   assign selOneHot = (light_sel == 3'b001) || (light_sel == 3'b010) || (light_sel == 3'b100);

   // Digit i is blanked only when it and every more significant digit are zero.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign zeroDigit[gi] = (displayVal[4*gi +: 4] == 4'd0);
      if (gi == 0) begin : g_units
         assign blankDigit[gi] = 1'b0;
      end else begin : g_upper
         assign blankDigit[gi] = (LZ_BLANK != 0) && (&zeroDigit[NUM_DIGITS-1:gi]);
      end
      assign segTable[gi]  = blankDigit[gi] ? SEG_BLANK : bcd_to_seg(displayVal[4*gi +: 4]);
      assign digOneHot[gi] = (curIdx == IDX_W'(gi));
   end

   assign digitSeg = segTable[digitIdx];

   // The slot registers hold what the current scan slot shows, so display
   // updates at a frame boundary never alter a digit that is already lit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digitIdx  <= '0;
         slotIdx   <= '0;
         slotSeg   <= SEG_BLANK;
         slotValid <= 1'b0;
      end else if (tick) begin
         digitIdx  <= (digitIdx == LAST_IDX) ? '0 : digitIdx + IDX_W'(1);
         slotIdx   <= digitIdx;
         slotSeg   <= digitSeg;
         slotValid <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pendingVal   <= '0;
         pendingValid <= 1'b0;
         displayVal   <= '0;
      end else begin
         if (load) begin
            pendingVal <= bcd_in;
         end
         if (frameEnd) begin
            if (load) begin
               displayVal <= bcd_in;
            end else if (pendingValid) begin
               displayVal <= pendingVal;
            end
            pendingValid <= 1'b0;
         end else if (load) begin
            pendingValid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blinkCnt   <= '0;
         blinkPhase <= 1'b0;
      end else if (mode != MODE_NIGHT) begin
         blinkCnt   <= '0;
         blinkPhase <= 1'b0;
      end else if (tick) begin
         if (blinkCnt == LAST_BLINK) begin
            blinkCnt   <= '0;
            blinkPhase <= ~blinkPhase;
         end else begin
            blinkCnt <= blinkCnt + BLINK_W'(1);
         end
      end
   end

   always_comb begin
      curValid = tick | slotValid;
      curIdx   = tick ? digitIdx : slotIdx;
      curSeg   = tick ? digitSeg : slotSeg;
      segNext  = SEG_BLANK;
      digNext  = '0;
      lampNext = 3'b000;
      case (mode)
         MODE_NORMAL: begin
            lampNext = selOneHot ? light_sel : 3'b001;
            if (curValid) begin
               segNext = curSeg;
               digNext = digOneHot;
            end
         end
         MODE_NIGHT: begin
            lampNext = {1'b0, blinkPhase, 1'b0};
         end
         MODE_OFF: begin
            lampNext = 3'b000;
         end
         default: begin
            lampNext = 3'b111;
            if (curValid) begin
               segNext = SEG_8;
               digNext = digOneHot;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_red    <= 1'b0;
         led_yellow <= 1'b0;
         led_green  <= 1'b0;
         seg        <= SEG_INV;
         dig_en     <= DIG_INV;
      end else begin
         led_red    <= lampNext[0];
         led_yellow <= lampNext[1];
         led_green  <= lampNext[2];
         seg        <= segNext ^ SEG_INV;
         dig_en     <= digNext ^ DIG_INV;
      end
   end

endmodule

// File: tb/tb_traffic_display_mux.sv
// Bench for traffic_display_mux: three instances (default, no blanking,
// active-low pins) share stimulus; scan slots are checked from a queue.
module tb_traffic_display_mux;

   logic       clk;
   logic       rst_n;
   logic [2:0] light_sel;
   logic [1:0] mode;
   logic [7:0] bcd_in;
   logic       load;

   logic       aRed, aYellow, aGreen;
   logic [6:0] aSeg;
   logic [1:0] aDig;
   logic       bRed, bYellow, bGreen;
   logic [6:0] bSeg;
   logic [1:0] bDig;
   logic       cRed, cYellow, cGreen;
   logic [6:0] cSeg;
   logic [1:0] cDig;

   int passCnt  = 0;
   int checkCnt = 0;

   typedef struct {
      logic [1:0] dig;
      logic [6:0] segA;
      logic [6:0] segB;
   } slot_t;
   slot_t expQ[$];

   traffic_display_mux #(.NUM_DIGITS(2), .SCAN_DIV(4), .BLINK_TICKS(2), .ACTIVE_LOW(0), .LZ_BLANK(1)) dutA (
      .clk(clk), .rst_n(rst_n), .light_sel(light_sel), .mode(mode), .bcd_in(bcd_in), .load(load),
      .led_red(aRed), .led_yellow(aYellow), .led_green(aGreen), .seg(aSeg), .dig_en(aDig));

   traffic_display_mux #(.NUM_DIGITS(2), .SCAN_DIV(4), .BLINK_TICKS(2), .ACTIVE_LOW(0), .LZ_BLANK(0)) dutB (
      .clk(clk), .rst_n(rst_n), .light_sel(light_sel), .mode(mode), .bcd_in(bcd_in), .load(load),
      .led_red(bRed), .led_yellow(bYellow), .led_green(bGreen), .seg(bSeg), .dig_en(bDig));

   traffic_display_mux #(.NUM_DIGITS(2), .SCAN_DIV(4), .BLINK_TICKS(2), .ACTIVE_LOW(1), .LZ_BLANK(1)) dutC (
      .clk(clk), .rst_n(rst_n), .light_sel(light_sel), .mode(mode), .bcd_in(bcd_in), .load(load),
      .led_red(cRed), .led_yellow(cYellow), .led_green(cGreen), .seg(cSeg), .dig_en(cDig));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic waitEdges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      waitEdges(2);
      checkCnt++; if ({aRed, aYellow, aGreen, aSeg, aDig} !== 12'h000) $display("FAIL reset_a: got %h expected 000", {aRed, aYellow, aGreen, aSeg, aDig}); else passCnt++;
      @(negedge clk) rst_n = 1'b1;
      waitEdges(2);
      checkCnt++; if (aRed !== 1'b1) $display("FAIL pre_pulse_red: got %b expected 1", aRed); else passCnt++;
      #2 rst_n = 1'b0;
      #1;
      checkCnt++; if ({aRed, aYellow, aGreen, aSeg, aDig} !== 12'h000) $display("FAIL async_reset_a: got %h expected 000", {aRed, aYellow, aGreen, aSeg, aDig}); else passCnt++;
      checkCnt++; if ({cRed, cYellow, cGreen} !== 3'b000 || cSeg !== 7'h7F || cDig !== 2'b11) $display("FAIL async_reset_c: got lamps %b seg %h dig %b expected 000 7f 11", {cRed, cYellow, cGreen}, cSeg, cDig); else passCnt++;
      @(negedge clk) rst_n = 1'b1;
      waitEdges(3);
      checkCnt++; if (aDig !== 2'b00) $display("FAIL pre_tick_dig: got %b expected 00", aDig); else passCnt++;
      checkCnt++; if (aRed !== 1'b1) $display("FAIL post_reset_red: got %b expected 1", aRed); else passCnt++;
      waitEdges(1);
      checkCnt++; if (aDig !== 2'b01 || aSeg !== 7'h7E) $display("FAIL first_tick: got dig %b seg %h expected 01 7e", aDig, aSeg); else passCnt++;
      $display("reset: first scan slot dig %b seg %h", aDig, aSeg);
   endtask

   task automatic test_load;
      slot_t e;
      light_sel = 3'b100; load = 1'b1; bcd_in = 8'h27;
      waitEdges(1);
      load = 1'b0;
      checkCnt++; if ({aRed, aYellow, aGreen} !== 3'b001) $display("FAIL green_lamp: got rgy-g %b expected 001", {aRed, aYellow, aGreen}); else passCnt++;
      checkCnt++; if (aDig !== 2'b01 || aSeg !== 7'h7E) $display("FAIL mid_frame_hold: got dig %b seg %h expected 01 7e", aDig, aSeg); else passCnt++;
      expQ.push_back('{2'b10, 7'h00, 7'h7E});
      expQ.push_back('{2'b01, 7'h70, 7'h70});
      expQ.push_back('{2'b10, 7'h6D, 7'h6D});
      expQ.push_back('{2'b01, 7'h70, 7'h70});
      waitEdges(3);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) waitEdges(4);
         e = expQ.pop_front();
         $display("load slot %0d: dig %b segA %h segB %h", i, aDig, aSeg, bSeg);
         checkCnt++; if (aDig !== e.dig || aSeg !== e.segA) $display("FAIL load_slot_a: got dig %b seg %h expected %b %h", aDig, aSeg, e.dig, e.segA); else passCnt++;
         checkCnt++; if (bDig !== e.dig || bSeg !== e.segB) $display("FAIL load_slot_b: got dig %b seg %h expected %b %h", bDig, bSeg, e.dig, e.segB); else passCnt++;
      end
   endtask

   task automatic test_blank;
      slot_t e;
      load = 1'b1; bcd_in = 8'h05;
      waitEdges(1);
      load = 1'b0;
      expQ.push_back('{2'b10, 7'h6D, 7'h6D});
      expQ.push_back('{2'b01, 7'h5B, 7'h5B});
      expQ.push_back('{2'b10, 7'h00, 7'h7E});
      waitEdges(3);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) waitEdges(4);
         e = expQ.pop_front();
         $display("blank slot %0d: dig %b segA %h segB %h", i, aDig, aSeg, bSeg);
         checkCnt++; if (aDig !== e.dig || aSeg !== e.segA) $display("FAIL blank_slot_a: got dig %b seg %h expected %b %h", aDig, aSeg, e.dig, e.segA); else passCnt++;
         checkCnt++; if (bDig !== e.dig || bSeg !== e.segB) $display("FAIL blank_slot_b: got dig %b seg %h expected %b %h", bDig, bSeg, e.dig, e.segB); else passCnt++;
      end
      load = 1'b1; bcd_in = 8'hA3;
      waitEdges(1);
      load = 1'b0;
      expQ.push_back('{2'b01, 7'h5B, 7'h5B});
      expQ.push_back('{2'b10, 7'h00, 7'h7E});
      expQ.push_back('{2'b01, 7'h79, 7'h79});
      expQ.push_back('{2'b10, 7'h01, 7'h01});
      waitEdges(3);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) waitEdges(4);
         e = expQ.pop_front();
         $display("dash slot %0d: dig %b segA %h segB %h", i, aDig, aSeg, bSeg);
         checkCnt++; if (aDig !== e.dig || aSeg !== e.segA) $display("FAIL dash_slot_a: got dig %b seg %h expected %b %h", aDig, aSeg, e.dig, e.segA); else passCnt++;
         checkCnt++; if (bDig !== e.dig || bSeg !== e.segB) $display("FAIL dash_slot_b: got dig %b seg %h expected %b %h", bDig, bSeg, e.dig, e.segB); else passCnt++;
      end
   endtask

   task automatic test_back_to_back;
      slot_t e;
      load = 1'b1; bcd_in = 8'h12;
      waitEdges(1);
      bcd_in = 8'h34;
      waitEdges(1);
      load = 1'b0;
      expQ.push_back('{2'b01, 7'h79, 7'h79});
      expQ.push_back('{2'b10, 7'h01, 7'h01});
      expQ.push_back('{2'b01, 7'h33, 7'h33});
      expQ.push_back('{2'b10, 7'h79, 7'h79});
      expQ.push_back('{2'b01, 7'h33, 7'h33});
      waitEdges(2);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) waitEdges(4);
         e = expQ.pop_front();
         $display("last-wins slot %0d: dig %b segA %h", i, aDig, aSeg);
         checkCnt++; if (aDig !== e.dig || aSeg !== e.segA) $display("FAIL last_wins_slot: got dig %b seg %h expected %b %h", aDig, aSeg, e.dig, e.segA); else passCnt++;
      end
      expQ.push_back('{2'b10, 7'h79, 7'h79});
      expQ.push_back('{2'b01, 7'h5F, 7'h5F});
      expQ.push_back('{2'b10, 7'h7B, 7'h7B});
      waitEdges(3);
      load = 1'b1; bcd_in = 8'h96;
      waitEdges(1);
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) waitEdges(4);
         e = expQ.pop_front();
         $display("boundary-load slot %0d: dig %b segA %h", i, aDig, aSeg);
         checkCnt++; if (aDig !== e.dig || aSeg !== e.segA) $display("FAIL boundary_load_slot: got dig %b seg %h expected %b %h", aDig, aSeg, e.dig, e.segA); else passCnt++;
      end
   endtask

   task automatic test_failsafe;
      logic [2:0] selTab [4];
      logic [2:0] expTab [4];
      selTab = '{3'b011, 3'b000, 3'b010, 3'b111};
      expTab = '{3'b001, 3'b001, 3'b010, 3'b001};
      for (int i = 0; i < 4; i++) begin
         light_sel = selTab[i];
         waitEdges(1);
         $display("lamps sel %b: red %b yellow %b green %b", selTab[i], aRed, aYellow, aGreen);
         checkCnt++; if ({aGreen, aYellow, aRed} !== expTab[i]) $display("FAIL failsafe_lamps: got gyr %b expected %b", {aGreen, aYellow, aRed}, expTab[i]); else passCnt++;
      end
   endtask

   task automatic test_night;
      int  hiLen;
      int  loLen;
      int  digBad;
      bit  found;
      light_sel = 3'b100; mode = 2'b01;
      waitEdges(1);
      checkCnt++; if ({aRed, aYellow, aGreen} !== 3'b000 || aDig !== 2'b00) $display("FAIL night_entry: got lamps %b dig %b expected 000 00", {aRed, aYellow, aGreen}, aDig); else passCnt++;
      found = 1'b0; digBad = 0;
      for (int i = 0; i < 24 && !found; i++) begin
         waitEdges(1);
         if (aDig !== 2'b00) digBad++;
         if (aYellow === 1'b1) found = 1'b1;
      end
      checkCnt++; if (!found) $display("FAIL night_first_flash: got no yellow within 24 clk, expected a flash"); else passCnt++;
      hiLen = 1;
      for (int i = 0; i < 20; i++) begin
         waitEdges(1);
         if (aDig !== 2'b00 || aRed !== 1'b0 || aGreen !== 1'b0) digBad++;
         if (aYellow !== 1'b1) break;
         hiLen++;
      end
      loLen = 1;
      for (int i = 0; i < 20; i++) begin
         waitEdges(1);
         if (aDig !== 2'b00 || aRed !== 1'b0 || aGreen !== 1'b0) digBad++;
         if (aYellow !== 1'b0) break;
         loLen++;
      end
      $display("night: yellow high %0d clk, low %0d clk", hiLen, loLen);
      checkCnt++; if (hiLen !== 8) $display("FAIL night_high_len: got %0d expected 8", hiLen); else passCnt++;
      checkCnt++; if (loLen !== 8) $display("FAIL night_low_len: got %0d expected 8", loLen); else passCnt++;
      checkCnt++; if (digBad !== 0) $display("FAIL night_dark_digits: got %0d bad cycles expected 0", digBad); else passCnt++;
      mode = 2'b11;
      waitEdges(1);
      checkCnt++; if ({aRed, aYellow, aGreen} !== 3'b111) $display("FAIL test_lamps: got %b expected 111", {aRed, aYellow, aGreen}); else passCnt++;
      digBad = 0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) waitEdges(1);
         if (aSeg !== 7'h7F || !(aDig == 2'b01 || aDig == 2'b10)) digBad++;
      end
      $display("lamp test: seg %h dig %b", aSeg, aDig);
      checkCnt++; if (digBad !== 0) $display("FAIL test_segments: got %0d cycles not 7f/one-hot expected 0", digBad); else passCnt++;
   endtask

   task automatic test_active_low;
      int sawUnits;
      int bad;
      mode = 2'b10;
      waitEdges(1);
      checkCnt++; if (cSeg !== 7'h7F || cDig !== 2'b11) $display("FAIL off_active_low: got seg %h dig %b expected 7f 11", cSeg, cDig); else passCnt++;
      checkCnt++; if ({aRed, aYellow, aGreen, aSeg, aDig} !== 12'h000) $display("FAIL off_active_high: got %h expected 000", {aRed, aYellow, aGreen, aSeg, aDig}); else passCnt++;
      mode = 2'b00; load = 1'b1; bcd_in = 8'h01;
      waitEdges(1);
      load = 1'b0;
      waitEdges(16);
      sawUnits = 0; bad = 0;
      for (int i = 0; i < 8; i++) begin
         waitEdges(1);
         if (cDig == 2'b10) begin
            sawUnits++;
            if (cSeg !== 7'h4F) bad++;
         end else if (cDig == 2'b01) begin
            if (cSeg !== 7'h7F) bad++;
         end else begin
            bad++;
         end
      end
      $display("active-low: units slots %0d, bad cycles %0d", sawUnits, bad);
      checkCnt++; if (bad !== 0) $display("FAIL active_low_scan: got %0d bad cycles expected 0", bad); else passCnt++;
      checkCnt++; if (sawUnits == 0) $display("FAIL active_low_units: got %0d units cycles expected at least 1", sawUnits); else passCnt++;
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; bcd_in = 8'h00; light_sel = 3'b001; mode = 2'b00;
      test_reset();
      test_load();
      test_blank();
      test_back_to_back();
      test_failsafe();
      test_night();
      test_active_low();
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
